i2c_txn_arbiter: RTL

- Shares one I2C controller engine among NUM_REQ requesters.
- The engine performs fixed 3-byte transactions: a 7-bit address phase, then 3 data bytes written or read.
- This block arbitrates round-robin and drives the engine's start/address/rw/write-data.
- It also enforces a per-transaction watchdog and a bus-free gap between transactions, and returns status and read data to the winning requester.

---
 rtl/i2c_txn_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/i2c_txn_arbiter.sv
// ============================================================================
//  Module      : i2c_txn_arbiter
//  Description : Round-robin arbiter sharing one 3-byte I2C engine among
//                NUM_REQ requesters, with watchdog abort and bus-free gap.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_txn_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 20000,
    parameter int GAP     = 500
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [7*NUM_REQ-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]     req_rw,
    input  logic [24*NUM_REQ-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [1:0]             rsp_status,
    output logic [23:0]            rsp_rdata,
    output logic                   ctl_start,
    output logic [6:0]             ctl_addr,
    output logic                   ctl_rw,
    output logic [23:0]            ctl_wdata,
    output logic                   ctl_abort,
    input  logic                   ctl_done,
    input  logic                   ctl_nack,
    input  logic [23:0]            ctl_rdata
);

    localparam int          IW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    localparam logic [9:0]  GAP_LAST     = (GAP == 0) ? 10'd0 : 10'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_RESP   = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;
    logic [15:0]   timer;
    logic [9:0]    gap_cnt;
    logic [1:0]    status_q;
    logic [23:0]   rdata_q;

    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [6:0]    sel_addr;
    logic          sel_rw;
    logic [23:0]   sel_wdata;
    int            cand;

    // Search starts at ptr and wraps, so the last winner is visited last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        sel_addr  = '0;
        sel_rw    = 1'b0;
        sel_wdata = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = IW'(cand);
                sel_addr  = req_addr[7*cand +: 7];
                sel_rw    = req_rw[cand];
                sel_wdata = req_wdata[24*cand +: 24];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && win_found && !rst) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state == S_RESP) begin
            rsp_valid[idx] = 1'b1;
        end
    end

    assign rsp_status = (state == S_RESP) ? status_q : 2'b00;
    assign rsp_rdata  = (state == S_RESP) ? rdata_q  : 24'd0;
    assign ctl_start  = (state == S_LAUNCH);
    // Engine completion on the final watchdog cycle takes precedence over abort.
    assign ctl_abort  = (state == S_WAIT) && !ctl_done && (timer == TIMEOUT_LAST) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            idx       <= '0;
            timer     <= '0;
            gap_cnt   <= '0;
            status_q  <= 2'b00;
            rdata_q   <= '0;
            ctl_addr  <= '0;
            ctl_rw    <= 1'b0;
            ctl_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        idx       <= win_idx;
                        ctl_addr  <= sel_addr;
                        ctl_rw    <= sel_rw;
                        ctl_wdata <= sel_wdata;
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer + 16'd1;
                    if (ctl_done) begin
                        status_q <= ctl_nack ? 2'b01 : 2'b00;
                        rdata_q  <= (ctl_rw && !ctl_nack) ? ctl_rdata : 24'd0;
                        state    <= S_RESP;
                    end else if (timer == TIMEOUT_LAST) begin
                        status_q <= 2'b10;
                        rdata_q  <= '0;
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    ptr     <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
                    gap_cnt <= '0;
                    state   <= (GAP == 0) ? S_IDLE : S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 10'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
